// File: rtl/lz4_sequence_ctrl.sv
// lz4_sequence_ctrl: parses one raw LZ4 block into literal bytes and (offset, length) match commands.
// Optional macro LZ4_CTRL_OFFSET_CHECK_EN rejects offsets of zero or beyond the bytes produced so far.
module lz4_sequence_ctrl #(
  parameter int unsigned LEN_W = 16,
  parameter int unsigned BLK_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BLK_W-1:0] block_len,
  input  logic [7:0]       in_data,
  input  logic             in_exists,
  output logic             in_read,
  output logic [7:0]       lit_data,
  output logic             lit_valid,
  input  logic             lit_ready,
  output logic [15:0]      match_offset,
  output logic [LEN_W-1:0] match_len,
  output logic             match_valid,
  input  logic             match_ready,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code
);

  localparam int unsigned SUM_W = LEN_W + 2;
  localparam logic [SUM_W-1:0] LEN_MAX = {2'b00, {LEN_W{1'b1}}};
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_TRUNC = 2'd1;
  localparam logic [1:0] ERR_OVF   = 2'd2;
  localparam logic [1:0] ERR_OFF   = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_TOKEN, S_LIT_EXT, S_LITERALS, S_OFF_LO,
    S_OFF_HI, S_MATCH_EXT, S_EMIT, S_DONE, S_ERROR
  } state_t;

  state_t           state;
  logic [BLK_W-1:0] remaining;
  logic             pending;
  logic [LEN_W-1:0] lit;
  logic [LEN_W-1:0] mlen;
  logic [7:0]       off_lo;

  logic             need_byte;
  logic             fetch_ok;
  logic             starved;
  logic             accept_start;
  logic             offset_bad;
  logic [SUM_W-1:0] lit_sum;
  logic [SUM_W-1:0] mlen_sum;
  logic [SUM_W-1:0] mlen_fin;

  // Which states consume a byte from the buffer
  always_comb begin
    need_byte = 1'b0;
    case (state)
      S_TOKEN, S_LIT_EXT, S_OFF_LO, S_OFF_HI, S_MATCH_EXT: need_byte = 1'b1;
      S_LITERALS: need_byte = (lit != '0);
      default: need_byte = 1'b0;
    endcase
  end

  // One read in flight; a held literal blocks the next literal fetch
  assign fetch_ok     = need_byte && !pending && !((state == S_LITERALS) && lit_valid);
  assign in_read      = fetch_ok && in_exists && (remaining != '0);
  assign starved      = fetch_ok && (remaining == '0);
  assign accept_start = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));

  assign lit_sum  = SUM_W'(lit) + SUM_W'(in_data);
  assign mlen_sum = SUM_W'(mlen) + SUM_W'(in_data);
  assign mlen_fin = mlen_sum + SUM_W'(4);

  assign busy  = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign done  = (state == S_DONE);
  assign error = (state == S_ERROR);

`ifdef LZ4_CTRL_OFFSET_CHECK_EN
  localparam int unsigned PSUM_W = ((LEN_W > 16) ? LEN_W : 16) + 1;
  logic [15:0]       produced;
  logic [PSUM_W-1:0] prod_sum;

  assign prod_sum   = PSUM_W'(produced) + PSUM_W'(match_len);
  assign offset_bad = ({in_data, off_lo} == 16'h0000) || ({in_data, off_lo} > produced);

  // Saturating count of decoded output bytes (literals plus accepted match lengths)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      produced <= '0;
    end else if (accept_start) begin
      produced <= '0;
    end else if ((state == S_LITERALS) && pending) begin
      if (produced != 16'hFFFF) produced <= produced + 16'd1;
    end else if ((state == S_EMIT) && match_ready) begin
      produced <= (prod_sum > PSUM_W'(16'hFFFF)) ? 16'hFFFF : prod_sum[15:0];
    end
  end
`else
  assign offset_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      remaining    <= '0;
      pending      <= 1'b0;
      lit          <= '0;
      mlen         <= '0;
      off_lo       <= '0;
      lit_data     <= '0;
      lit_valid    <= 1'b0;
      match_offset <= '0;
      match_len    <= '0;
      match_valid  <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      pending <= in_read;
      if (in_read) remaining <= remaining - BLK_W'(1);
      if (lit_valid && lit_ready) lit_valid <= 1'b0;

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            remaining <= block_len;
            pending   <= 1'b0;
            if (block_len == '0) begin
              state    <= S_ERROR;
              err_code <= ERR_TRUNC;
            end else begin
              state    <= S_TOKEN;
              err_code <= ERR_NONE;
            end
          end
        end

        S_TOKEN: begin
          if (pending) begin
            lit  <= LEN_W'(in_data[7:4]);
            mlen <= LEN_W'(in_data[3:0]);
            if (in_data[7:4] == 4'hF)      state <= S_LIT_EXT;
            else if (in_data[7:4] != 4'h0) state <= S_LITERALS;
            else                           state <= S_OFF_LO;
          end
        end

        S_LIT_EXT: begin
          if (pending) begin
            if (lit_sum > LEN_MAX) begin
              state    <= S_ERROR;
              err_code <= ERR_OVF;
            end else begin
              lit <= LEN_W'(lit_sum);
              if (in_data != 8'hFF) state <= S_LITERALS;
            end
          end
        end

        S_LITERALS: begin
          if (pending) begin
            lit_data  <= in_data;
            lit_valid <= 1'b1;
            lit       <= lit - LEN_W'(1);
          end else if ((lit == '0) && !lit_valid) begin
            // A block may only end right after a literal run
            state <= (remaining == '0) ? S_DONE : S_OFF_LO;
          end
        end

        S_OFF_LO: begin
          if (pending) begin
            off_lo <= in_data;
            state  <= S_OFF_HI;
          end
        end

        S_OFF_HI: begin
          if (pending) begin
            match_offset <= {in_data, off_lo};
            if (offset_bad) begin
              state    <= S_ERROR;
              err_code <= ERR_OFF;
            end else if (mlen == LEN_W'(15)) begin
              state <= S_MATCH_EXT;
            end else begin
              match_len   <= LEN_W'(SUM_W'(mlen) + SUM_W'(4));
              match_valid <= 1'b1;
              state       <= S_EMIT;
            end
          end
        end

        S_MATCH_EXT: begin
          if (pending) begin
            if (mlen_fin > LEN_MAX) begin
              state    <= S_ERROR;
              err_code <= ERR_OVF;
            end else begin
              mlen <= LEN_W'(mlen_sum);
              if (in_data != 8'hFF) begin
                match_len   <= LEN_W'(mlen_fin);
                match_valid <= 1'b1;
                state       <= S_EMIT;
              end
            end
          end
        end

        S_EMIT: begin
          if (match_ready) begin
            match_valid <= 1'b0;
            if (remaining != '0) begin
              state <= S_TOKEN;
            end else begin
              state    <= S_ERROR;
              err_code <= ERR_TRUNC;
            end
          end
        end

        default: state <= S_IDLE;
      endcase

      // Byte needed but the block budget is exhausted
      if (starved) begin
        state    <= S_ERROR;
        err_code <= ERR_TRUNC;
      end
    end
  end

endmodule

// File: tb/tb_lz4_sequence_ctrl.sv
// Bench for lz4_sequence_ctrl: directed and random LZ4 blocks checked against a block-level decoder model.
module tb_lz4_sequence_ctrl;

  localparam int unsigned LEN_W = 16;
  localparam int unsigned BLK_W = 16;
  localparam int LEN_MAX = 65535;
  localparam int CYC_LIMIT = 20000;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [BLK_W-1:0] block_len;
  logic [7:0]       in_data;
  logic             in_exists;
  logic             in_read;
  logic [7:0]       lit_data;
  logic             lit_valid;
  logic             lit_ready;
  logic [15:0]      match_offset;
  logic [LEN_W-1:0] match_len;
  logic             match_valid;
  logic             match_ready;
  logic             busy;
  logic             done;
  logic             error;
  logic [1:0]       err_code;

  lz4_sequence_ctrl #(.LEN_W(LEN_W), .BLK_W(BLK_W)) dut (
    .clk(clk), .reset(reset), .start(start), .block_len(block_len),
    .in_data(in_data), .in_exists(in_exists), .in_read(in_read),
    .lit_data(lit_data), .lit_valid(lit_valid), .lit_ready(lit_ready),
    .match_offset(match_offset), .match_len(match_len), .match_valid(match_valid),
    .match_ready(match_ready), .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  int          mode;
  int          mwait;
  bit          exists_en;
  logic [7:0]  blk[$];
  logic [7:0]  buf_q[$];
  logic [7:0]  got_lits[$];
  logic [31:0] got_m[$];
  int          reads_seen;
  int          unstable;
  bit          m_hold;
  logic [31:0] m_held;

  logic [7:0]  exp_lits[$];
  logic [31:0] exp_m[$];
  int          exp_err;
  bit          exp_done;
  int          exp_reads;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decoder: walks the block byte array by the LZ4 sequence rules
  function automatic bit fetch(inout int pos, output int b);
    if (pos >= blk.size()) begin
      exp_err = 1;
      b = 0;
      return 1'b0;
    end
    b = int'(blk[pos]);
    pos++;
    return 1'b1;
  endfunction

  task automatic ref_model();
    int pos, tok, lit, ml, off, produced, b;
    exp_lits.delete();
    exp_m.delete();
    exp_err = 0;
    exp_done = 0;
    pos = 0;
    produced = 0;
    while (exp_err == 0 && !exp_done) begin
      if (!fetch(pos, tok)) break;
      lit = tok / 16;
      ml  = tok % 16;
      if (lit == 15) begin
        do begin
          if (!fetch(pos, b)) break;
          lit += b;
          if (lit > LEN_MAX) exp_err = 2;
        end while (b == 255 && exp_err == 0);
        if (exp_err != 0) break;
      end
      for (int i = 0; i < lit; i++) begin
        if (!fetch(pos, b)) break;
        exp_lits.push_back(8'(b));
        produced = (produced < 65535) ? produced + 1 : 65535;
      end
      if (exp_err != 0) break;
      if (lit > 0 && pos == blk.size()) begin
        exp_done = 1;
        break;
      end
      if (!fetch(pos, b)) break;
      off = b;
      if (!fetch(pos, b)) break;
      off += 256 * b;
`ifdef LZ4_CTRL_OFFSET_CHECK_EN
      if (off == 0 || off > produced) begin
        exp_err = 3;
        break;
      end
`endif
      ml += 4;
      if (ml == 19) begin
        do begin
          if (!fetch(pos, b)) break;
          ml += b;
          if (ml > LEN_MAX) exp_err = 2;
        end while (b == 255 && exp_err == 0);
        if (exp_err != 0) break;
      end
      exp_m.push_back({16'(off), 16'(ml)});
      produced = (produced + ml > 65535) ? 65535 : produced + ml;
      if (pos == blk.size()) begin
        exp_err = 1;
        break;
      end
    end
    exp_reads = pos;
  endtask

  // Block encoder used by the random generator
  task automatic put_ext(input int v);
    int r;
    r = v;
    while (r >= 255) begin
      blk.push_back(8'hFF);
      r -= 255;
    end
    blk.push_back(8'(r));
  endtask

  task automatic put_seq(input int nlit, input bit has_m, input int off, input int mval);
    int lnib, mc, mnib;
    lnib = (nlit >= 15) ? 15 : nlit;
    mc   = has_m ? mval - 4 : mval;
    mnib = (mc >= 15) ? 15 : mc;
    blk.push_back(8'(lnib * 16 + mnib));
    if (lnib == 15) put_ext(nlit - 15);
    for (int i = 0; i < nlit; i++) blk.push_back(8'($urandom));
    if (has_m) begin
      blk.push_back(8'(off));
      blk.push_back(8'(off >> 8));
      if (mnib == 15) put_ext(mc - 15);
    end
  endtask

  task automatic gen_random();
    int nseq, nlit, mlen, off, produced;
    blk.delete();
    produced = 0;
    nseq = int'($urandom_range(1, 4));
    for (int s = 0; s < nseq; s++) begin
      nlit = ($urandom_range(0, 5) == 0) ? int'($urandom_range(15, 300)) : int'($urandom_range(0, 14));
      if (s == 0 && nlit == 0) nlit = 1;
      if (s == nseq - 1) begin
        put_seq(nlit, 1'b0, 0, int'($urandom_range(0, 15)));
      end else begin
        mlen = ($urandom_range(0, 4) == 0) ? int'($urandom_range(19, 600)) : int'($urandom_range(4, 18));
        off  = int'($urandom_range(1, produced + nlit));
        put_seq(nlit, 1'b1, off, mlen);
        produced += nlit + mlen;
      end
    end
  endtask

  // One clock: drive at negedge, sample handshakes mid-cycle, deliver read byte after posedge
  task automatic tick();
    logic [7:0] nxt;
    bit rd;
    @(negedge clk);
    case (mode)
      1: begin
        lit_ready   = ($urandom_range(0, 3) != 0);
        match_ready = ($urandom_range(0, 1) != 0);
        exists_en   = ($urandom_range(0, 3) != 0);
      end
      2: begin
        lit_ready   = 1'b1;
        match_ready = (mwait >= 20);
        exists_en   = !exists_en;
        if (match_valid) mwait++;
      end
      default: begin
        lit_ready   = 1'b1;
        match_ready = 1'b1;
        exists_en   = 1'b1;
      end
    endcase
    in_exists = exists_en && (buf_q.size() > 0);
    #1;
    if (lit_valid && lit_ready) got_lits.push_back(lit_data);
    if (match_valid && match_ready) got_m.push_back({match_offset, match_len});
    if (m_hold && !(match_valid && ({match_offset, match_len} == m_held))) unstable++;
    m_hold = match_valid && !match_ready;
    m_held = {match_offset, match_len};
    rd  = in_read;
    nxt = in_data;
    if (rd) begin
      reads_seen++;
      if (buf_q.size() > 0) nxt = buf_q.pop_front();
    end
    @(posedge clk);
    #1;
    in_data = nxt;
  endtask

  task automatic launch(input int m);
    mode = m;
    mwait = 0;
    exists_en = 1'b1;
    buf_q = blk;
    got_lits.delete();
    got_m.delete();
    reads_seen = 0;
    unstable = 0;
    m_hold = 1'b0;
    start = 1'b1;
    block_len = BLK_W'(blk.size());
    tick();
    start = 1'b0;
  endtask

  task automatic run_block(input string tag, input int m);
    int cyc;
    int nl, nm;
    ref_model();
    launch(m);
    check({tag, " busy after start"}, 32'(busy), 32'(blk.size() != 0));
    if (blk.size() == 0) begin
      check({tag, " error next cycle"}, 32'(error), 32'd1);
      check({tag, " err_code next cycle"}, 32'(err_code), 32'd1);
    end
    cyc = 0;
    while (!(done || error) && cyc < CYC_LIMIT) begin
      tick();
      cyc++;
    end
    check({tag, " finished in budget"}, 32'(done || error), 32'd1);
    repeat (4) tick();
    check({tag, " done"}, 32'(done), 32'(exp_done));
    check({tag, " error"}, 32'(error), 32'(exp_err != 0));
    check({tag, " err_code"}, 32'(err_code), 32'(exp_err));
    check({tag, " busy idle"}, 32'(busy), 32'd0);
    check({tag, " literal count"}, 32'(got_lits.size()), 32'(exp_lits.size()));
    nl = (got_lits.size() < exp_lits.size()) ? got_lits.size() : exp_lits.size();
    for (int i = 0; i < nl; i++) check($sformatf("%s lit[%0d]", tag, i), 32'(got_lits[i]), 32'(exp_lits[i]));
    check({tag, " match count"}, 32'(got_m.size()), 32'(exp_m.size()));
    nm = (got_m.size() < exp_m.size()) ? got_m.size() : exp_m.size();
    for (int i = 0; i < nm; i++) check($sformatf("%s match[%0d] off/len", tag, i), got_m[i], exp_m[i]);
    check({tag, " in_read pulses"}, 32'(reads_seen), 32'(exp_reads));
    check({tag, " match held stable"}, 32'(unstable), 32'd0);
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    start = 1'b0;
    block_len = '0;
    in_data = 8'h00;
    in_exists = 1'b0;
    lit_ready = 1'b0;
    match_ready = 1'b0;
    mode = 0;
    mwait = 0;
    exists_en = 1'b1;
    m_hold = 1'b0;
    m_held = '0;
    reads_seen = 0;
    unstable = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset lit_valid", 32'(lit_valid), 32'd0);
    check("reset match_valid", 32'(match_valid), 32'd0);
    check("reset done/error/busy", 32'({done, error, busy}), 32'd0);
    check("reset err_code", 32'(err_code), 32'd0);
    check("reset in_read", 32'(in_read), 32'd0);
    check("reset lit_data", 32'(lit_data), 32'd0);
    check("reset match off/len", 32'({match_offset, match_len}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    blk = '{8'h30, 8'h41, 8'h42, 8'h43};
    run_block("case1 literals only", 0);

    blk = '{8'h12, 8'h41, 8'h01, 8'h00, 8'h10, 8'h42};
    run_block("case2 literal+match", 0);

    blk = '{8'hF0, 8'hFF, 8'h02};
    for (int i = 0; i < 272; i++) blk.push_back(8'($urandom));
    run_block("case3 long literal run", 0);

    blk = '{8'h12, 8'h41, 8'h01, 8'h00, 8'h10, 8'h42};
    run_block("case4 match backpressure", 2);

    blk = '{8'h12, 8'h41, 8'h01};
    run_block("case5 truncated", 0);

    blk = '{8'h10, 8'h41, 8'h00, 8'h00, 8'h10, 8'h42};
    run_block("case6 zero offset", 0);

    blk.delete();
    run_block("empty block", 0);

    blk = '{8'hF0};
    repeat (260) blk.push_back(8'hFF);
    run_block("literal length overflow", 0);

    blk = '{8'h1F, 8'h41, 8'h01, 8'h00};
    repeat (270) blk.push_back(8'hFF);
    run_block("match length overflow", 0);

    blk = '{8'h14, 8'h41, 8'h01, 8'h00};
    run_block("block ends on match", 1);

    // Reset in the middle of a literal run, then a clean block
    blk = '{8'hF0, 8'hFF, 8'h02};
    for (int i = 0; i < 272; i++) blk.push_back(8'($urandom));
    launch(0);
    cyc = 0;
    while (got_lits.size() < 10 && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("midreset reached literals", 32'(got_lits.size() >= 10), 32'd1);
    check("midreset busy before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("midreset lit_valid", 32'(lit_valid), 32'd0);
    check("midreset match_valid", 32'(match_valid), 32'd0);
    check("midreset in_read", 32'(in_read), 32'd0);
    check("midreset done/error/busy", 32'({done, error, busy}), 32'd0);
    check("midreset err_code", 32'(err_code), 32'd0);
    check("midreset lit_data", 32'(lit_data), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    buf_q.delete();
    blk = '{8'h30, 8'h41, 8'h42, 8'h43};
    run_block("case1 after reset", 0);

    for (int t = 0; t < 10; t++) begin
      gen_random();
      run_block($sformatf("random%0d", t), (t % 3 == 0) ? 0 : 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
